// File: rtl/lsu_pkg.sv
// Package: lsu_pkg
// Shared encodings for the load/store unit: access sizes, FSM states and byte-lane masks.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    typedef enum logic {IDLE, RMW} state_e;

    // The reserved size 2'b11 behaves as a word, so only the two low encodings are sub-word.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Module: lsu_lane_merge
// Combinational little-endian lane logic: extract/extend for loads, lane replace for stores.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [4:0]  lane_shift;
    logic [15:0] lane;
    logic [31:0] mask;

    assign lane_shift = {offset_i, 3'b000};
    assign lane       = 16'(word_i >> lane_shift);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        load_data_o = word_i;
        mask        = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{lane[7] & ~unsigned_i}}, lane[7:0]};
                mask        = BYTE_MASK << lane_shift;
            end
            SZ_HALF: begin
                load_data_o = {{16{lane[15] & ~unsigned_i}}, lane[15:0]};
                mask        = HALF_MASK << lane_shift;
            end
            default: ;
        endcase
        merged_o = (word_i & ~mask) | ((wdata_i << lane_shift) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Module: load_store_unit
// MEM-stage load/store front end with 2-cycle sub-word RMW; `define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_e      state_q;
    logic [29:0] idx_q;
    logic [31:0] merged_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [1:0]  offset;
    logic        misaligned;
    logic        subword;
    logic        in_range;
    logic        accept;
    logic        go;
    logic [31:0] load_data;
    logic [31:0] merged_d;

    always_comb begin
        offset     = req_addr[1:0];
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (req_size == SZ_HALF)       misaligned = req_addr[0];
        else if (req_size >= SZ_WORD)  misaligned = |req_addr[1:0];
`else
        if (req_size == SZ_HALF)       offset[0] = 1'b0;
        else if (req_size >= SZ_WORD)  offset    = 2'b00;
`endif
    end

    assign subword   = is_subword(req_size);
    assign in_range  = req_addr[31:2] < WORD_LIMIT;
    assign req_ready = (state_q == IDLE) && !RESET;
    assign accept    = req_valid && req_ready;
    assign go        = accept && in_range && !misaligned;

    // In RMW the memory port belongs to the pending write-back, not to the request bus.
    assign mem_addr  = (state_q == RMW) ? {2'b00, idx_q} : {2'b00, req_addr[31:2]};
    assign mem_read  = go && (!req_write || subword);
    assign mem_write = !RESET && ((state_q == RMW) || (go && req_write && !subword));
    assign mem_wdata = (state_q == RMW) ? merged_q : req_wdata;

    lsu_lane_merge u_lane_merge (
        .word_i      (mem_rdata),
        .offset_i    (offset),
        .size_i      (req_size),
        .unsigned_i  (req_unsigned),
        .wdata_i     (req_wdata),
        .load_data_o (load_data),
        .merged_o    (merged_d)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            merged_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        if (misaligned) begin
                            resp_err_q <= 1'b1;
                        end else if (in_range && !req_write) begin
                            resp_rdata_q <= load_data;
                        end else if (in_range && subword) begin
                            resp_valid_q <= 1'b0;
                            merged_q     <= merged_d;
                            idx_q        <= req_addr[31:2];
                            state_q      <= RMW;
                        end
                    end
                end
                RMW: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
